// File: rtl/sdc_port_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the SDRAM user-port arbiter.
// The arbiter connects through the master modport; the surrounding environment uses slave.
interface sdc_port_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic                   sdc_init_done;
  logic [3:0]             p_req;
  logic [4*ADDR_W-1:0]    p_req_adr;
  logic [7:0]             p_req_len;
  logic [3:0]             p_req_wr_n;
  logic [4*DATA_W-1:0]    p_wr_data;
  logic [4*BE_W-1:0]      p_wr_en_n;
  logic [3:0]             p_ack;
  logic [3:0]             p_wr_next;
  logic [3:0]             p_rd_valid;
  logic [DATA_W-1:0]      p_rd_data;
  logic [3:0]             grant;
  logic                   busy;
  logic                   sdc_req;
  logic [ADDR_W-1:0]      sdc_req_adr;
  logic [1:0]             sdc_req_len;
  logic                   sdc_req_wr_n;
  logic [DATA_W-1:0]      sdc_wr_data;
  logic [BE_W-1:0]        sdc_wr_en_n;
  logic                   sdc_req_ack;
  logic                   sdc_wr_next;
  logic                   sdc_rd_valid;
  logic [DATA_W-1:0]      sdc_rd_data;

  modport master (
    input  sdc_init_done, p_req, p_req_adr, p_req_len, p_req_wr_n, p_wr_data, p_wr_en_n,
    input  sdc_req_ack, sdc_wr_next, sdc_rd_valid, sdc_rd_data,
    output p_ack, p_wr_next, p_rd_valid, p_rd_data, grant, busy,
    output sdc_req, sdc_req_adr, sdc_req_len, sdc_req_wr_n, sdc_wr_data, sdc_wr_en_n
  );

  modport slave (
    output sdc_init_done, p_req, p_req_adr, p_req_len, p_req_wr_n, p_wr_data, p_wr_en_n,
    output sdc_req_ack, sdc_wr_next, sdc_rd_valid, sdc_rd_data,
    input  p_ack, p_wr_next, p_rd_valid, p_rd_data, grant, busy,
    input  sdc_req, sdc_req_adr, sdc_req_len, sdc_req_wr_n, sdc_wr_data, sdc_wr_en_n
  );
endinterface

// File: rtl/sdc_port_arbiter.sv
// Four-port round-robin arbiter in front of the SDRAM controller user port.
// Latches one request per grant and routes data beats to the owner until the burst ends.
module sdc_port_arbiter #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input logic              mclk,
  input logic              s_resetn,
  sdc_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          gidx_q, gidx_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [1:0]          len_q, len_d;
  logic                wr_n_q, wr_n_d;
  logic                req_q, req_d;
  logic [3:0]          ack_q, ack_d;
  logic [5:0]          beat_q, beat_d;
  logic [5:0]          last_beat;
  logic [1:0]          sel_idx;
  logic                sel_found;
  logic                beat_in;
  logic                busy;

  assign last_beat = (6'd4 << len_q) - 6'd1;
  assign beat_in   = wr_n_q ? bus.sdc_rd_valid : bus.sdc_wr_next;
  assign busy      = (state_q != IDLE);

  // Rotating priority: first requester found scanning from the last owner + 1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!sel_found && bus.p_req[2'(ptr_q + i)]) begin
        sel_found = 1'b1;
        sel_idx   = 2'(ptr_q + i);
      end
    end
  end

  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      gidx_q  <= '0;
      adr_q   <= '0;
      len_q   <= '0;
      wr_n_q  <= 1'b0;
      req_q   <= 1'b0;
      ack_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      wr_n_q  <= wr_n_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    adr_d   = adr_q;
    len_d   = len_q;
    wr_n_d  = wr_n_q;
    req_d   = req_q;
    ack_d   = '0;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.sdc_init_done && sel_found) begin
          gidx_d  = sel_idx;
          adr_d   = bus.p_req_adr[sel_idx*ADDR_W +: ADDR_W];
          len_d   = bus.p_req_len[sel_idx*2 +: 2];
          wr_n_d  = bus.p_req_wr_n[sel_idx];
          req_d   = 1'b1;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A beat arriving alongside the ack belongs to this burst.
        if (beat_in) beat_d = beat_q + 6'd1;
        if (bus.sdc_req_ack) begin
          req_d   = 1'b0;
          ack_d   = 4'b0001 << gidx_q;
          ptr_d   = gidx_q;
          state_d = wr_n_q ? RDATA : WDATA;
        end
      end
      WDATA, RDATA: begin
        if (beat_in) begin
          if (beat_q == last_beat) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = busy;
    bus.grant        = busy ? (4'b0001 << gidx_q) : '0;
    bus.p_ack        = ack_q;
    bus.p_wr_next    = (busy && !wr_n_q && bus.sdc_wr_next) ? (4'b0001 << gidx_q) : '0;
    bus.p_rd_valid   = (busy && wr_n_q && bus.sdc_rd_valid) ? (4'b0001 << gidx_q) : '0;
    bus.p_rd_data    = bus.sdc_rd_data;
    bus.sdc_req      = req_q;
    bus.sdc_req_adr  = adr_q;
    bus.sdc_req_len  = len_q;
    bus.sdc_req_wr_n = wr_n_q;
    bus.sdc_wr_data  = busy ? bus.p_wr_data[gidx_q*DATA_W +: DATA_W] : '0;
    bus.sdc_wr_en_n  = busy ? bus.p_wr_en_n[gidx_q*BE_W +: BE_W] : '1;
  end

endmodule

// File: tb/tb_sdc_port_arbiter.sv
// Directed bench for sdc_port_arbiter: gating, write/read bursts, rotation, ack-cycle beat, reset.
module tb_sdc_port_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic mclk;
  logic s_resetn;
  int   total;
  int   bad;

  sdc_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) ifc ();

  sdc_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .mclk    (mclk),
    .s_resetn(s_resetn),
    .bus     (ifc.master)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.sdc_init_done = 1'b0;
    ifc.p_req         = '0;
    ifc.p_req_adr     = '0;
    ifc.p_req_len     = '0;
    ifc.p_req_wr_n    = '1;
    ifc.p_wr_data     = '0;
    ifc.p_wr_en_n     = '1;
    ifc.sdc_req_ack   = 1'b0;
    ifc.sdc_wr_next   = 1'b0;
    ifc.sdc_rd_valid  = 1'b0;
    ifc.sdc_rd_data   = '0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.sdc_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic ack_now();
    ifc.sdc_req_ack = 1'b1;
    cyc();
    ifc.sdc_req_ack = 1'b0;
  endtask

  task automatic read_beats(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.sdc_rd_valid = 1'b1;
      cyc();
    end
    ifc.sdc_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    s_resetn = 1'b0;
    clear_inputs();
    #12;
    total++; if (ifc.sdc_req !== 1'b0) begin bad++; $display("FAIL rst_sdc_req got=%0h exp=0", ifc.sdc_req); end
    total++; if (ifc.grant !== 4'h0) begin bad++; $display("FAIL rst_grant got=%0h exp=0", ifc.grant); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", ifc.busy); end
    total++; if (ifc.p_ack !== 4'h0) begin bad++; $display("FAIL rst_p_ack got=%0h exp=0", ifc.p_ack); end
    total++; if (ifc.sdc_wr_en_n !== 4'hF) begin bad++; $display("FAIL rst_wr_en_n got=%0h exp=f", ifc.sdc_wr_en_n); end
    total++; if (ifc.sdc_req_adr !== 23'h0) begin bad++; $display("FAIL rst_adr got=%0h exp=0", ifc.sdc_req_adr); end
    cyc();
    s_resetn = 1'b1;
    cyc();
  endtask

  task automatic test_init_gate();
    ifc.p_req_adr[0 +: ADDR_W] = 23'h12345;
    ifc.p_req_wr_n = 4'b1111;
    ifc.p_req_len  = 8'h00;
    ifc.p_req      = 4'b0001;
    ifc.sdc_init_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (ifc.sdc_req !== 1'b0) begin bad++; $display("FAIL init_block_req cyc=%0d got=%0h exp=0", i, ifc.sdc_req); end
      total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL init_block_busy cyc=%0d got=%0h exp=0", i, ifc.busy); end
    end
    ifc.sdc_init_done = 1'b1;
    cyc();
    total++; if (ifc.sdc_req !== 1'b1) begin bad++; $display("FAIL init_req got=%0h exp=1", ifc.sdc_req); end
    total++; if (ifc.sdc_req_adr !== 23'h12345) begin bad++; $display("FAIL init_adr got=%0h exp=12345", ifc.sdc_req_adr); end
    total++; if (ifc.grant !== 4'b0001) begin bad++; $display("FAIL init_grant got=%0h exp=1", ifc.grant); end
    total++; if (ifc.sdc_req_wr_n !== 1'b1) begin bad++; $display("FAIL init_wr_n got=%0h exp=1", ifc.sdc_req_wr_n); end
    ack_now();
    ifc.p_req = 4'b0000;
    total++; if (ifc.p_ack !== 4'b0001) begin bad++; $display("FAIL init_p_ack got=%0h exp=1", ifc.p_ack); end
    total++; if (ifc.sdc_req !== 1'b0) begin bad++; $display("FAIL init_req_drop got=%0h exp=0", ifc.sdc_req); end
    cyc();
    total++; if (ifc.p_ack !== 4'b0000) begin bad++; $display("FAIL init_p_ack_pulse got=%0h exp=0", ifc.p_ack); end
    read_beats(4);
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL init_done_idle got=%0h exp=0", ifc.busy); end
  endtask

  task automatic test_write_burst();
    bit ok;
    int pulses;
    logic [31:0] wd;
    ifc.p_req_adr[2*ADDR_W +: ADDR_W] = 23'h2A5A5;
    ifc.p_req_len[5:4] = 2'd1;
    ifc.p_req_wr_n[2]  = 1'b0;
    ifc.p_wr_en_n[8 +: 4] = 4'b0101;
    ifc.p_req = 4'b0100;
    cyc();
    total++; if (ifc.grant !== 4'b0100) begin bad++; $display("FAIL wr_grant got=%0h exp=4", ifc.grant); end
    total++; if (ifc.sdc_req_len !== 2'd1) begin bad++; $display("FAIL wr_len got=%0h exp=1", ifc.sdc_req_len); end
    total++; if (ifc.sdc_req_wr_n !== 1'b0) begin bad++; $display("FAIL wr_dir got=%0h exp=0", ifc.sdc_req_wr_n); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (ifc.sdc_req !== 1'b1 || ifc.sdc_req_adr !== 23'h2A5A5) begin bad++; $display("FAIL wr_hold cyc=%0d got=%0h/%0h exp=1/2a5a5", i, ifc.sdc_req, ifc.sdc_req_adr); end
    end
    wait_req(ok);
    ack_now();
    ifc.p_req = 4'b0000;
    total++; if (ifc.p_ack !== 4'b0100) begin bad++; $display("FAIL wr_p_ack got=%0h exp=4", ifc.p_ack); end
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        ifc.sdc_wr_next = 1'b0;
        #1;
        total++; if (ifc.p_wr_next !== 4'b0000) begin bad++; $display("FAIL wr_gap got=%0h exp=0", ifc.p_wr_next); end
      end else begin
        wd = 32'hD000_0000 + 32'(i);
        ifc.p_wr_data[2*DATA_W +: DATA_W] = wd;
        ifc.sdc_wr_next = 1'b1;
        #1;
        if (ifc.p_wr_next[2] === 1'b1) pulses++;
        total++; if (ifc.p_wr_next !== 4'b0100) begin bad++; $display("FAIL wr_next_route beat=%0d got=%0h exp=4", i, ifc.p_wr_next); end
        total++; if (ifc.sdc_wr_data !== wd) begin bad++; $display("FAIL wr_data beat=%0d got=%0h exp=%0h", i, ifc.sdc_wr_data, wd); end
        total++; if (ifc.sdc_wr_en_n !== 4'b0101) begin bad++; $display("FAIL wr_en_n beat=%0d got=%0h exp=5", i, ifc.sdc_wr_en_n); end
        if (i == 8) begin
          total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL wr_busy_last got=%0h exp=1", ifc.busy); end
        end
      end
      cyc();
    end
    ifc.sdc_wr_next = 1'b0;
    total++; if (pulses !== 8) begin bad++; $display("FAIL wr_pulse_count got=%0d exp=8", pulses); end
    total++; if (ifc.busy !== 1'b0 || ifc.grant !== 4'h0) begin bad++; $display("FAIL wr_end got=%0h/%0h exp=0/0", ifc.busy, ifc.grant); end
  endtask

  task automatic test_read_burst();
    int routed;
    int leaked;
    ifc.p_req_adr[1*ADDR_W +: ADDR_W] = 23'h01111;
    ifc.p_req_len[3:2] = 2'd3;
    ifc.p_req_wr_n[1]  = 1'b1;
    ifc.p_req = 4'b0010;
    cyc();
    total++; if (ifc.grant !== 4'b0010) begin bad++; $display("FAIL rd_grant got=%0h exp=2", ifc.grant); end
    total++; if (ifc.sdc_req_len !== 2'd3) begin bad++; $display("FAIL rd_len got=%0h exp=3", ifc.sdc_req_len); end
    ack_now();
    ifc.p_req = 4'b0000;
    routed = 0;
    leaked = 0;
    for (int i = 0; i < 32; i++) begin
      ifc.sdc_rd_valid = 1'b1;
      ifc.sdc_rd_data  = 32'hBEEF_0000 + 32'(i);
      #1;
      if (ifc.p_rd_valid === 4'b0010 && ifc.p_rd_data === 32'hBEEF_0000 + 32'(i)) routed++;
      else leaked++;
      cyc();
    end
    total++; if (routed !== 32) begin bad++; $display("FAIL rd_routed got=%0d exp=32", routed); end
    total++; if (leaked !== 0) begin bad++; $display("FAIL rd_misrouted got=%0d exp=0", leaked); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rd_end_busy got=%0h exp=0", ifc.busy); end
    #1;
    total++; if (ifc.p_rd_valid !== 4'b0000) begin bad++; $display("FAIL rd_extra got=%0h exp=0", ifc.p_rd_valid); end
    cyc();
    ifc.sdc_rd_valid = 1'b0;
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rd_extra_busy got=%0h exp=0", ifc.busy); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_idx;
    s_resetn = 1'b0;
    cyc();
    s_resetn = 1'b1;
    cyc();
    for (int n = 0; n < 4; n++) ifc.p_req_adr[n*ADDR_W +: ADDR_W] = 23'h100 + 23'(n);
    ifc.p_req_len  = 8'h00;
    ifc.p_req_wr_n = 4'b1111;
    ifc.p_req      = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_idx = k % 4;
      wait_req(ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_req_timeout k=%0d got=0 exp=1", k); end
      total++; if (ifc.grant !== (4'b0001 << exp_idx)) begin bad++; $display("FAIL rr_grant k=%0d got=%0h exp=%0h", k, ifc.grant, 4'b0001 << exp_idx); end
      total++; if (ifc.sdc_req_adr !== 23'h100 + 23'(exp_idx)) begin bad++; $display("FAIL rr_adr k=%0d got=%0h exp=%0h", k, ifc.sdc_req_adr, 23'h100 + 23'(exp_idx)); end
      ack_now();
      total++; if (ifc.p_ack !== (4'b0001 << exp_idx)) begin bad++; $display("FAIL rr_p_ack k=%0d got=%0h exp=%0h", k, ifc.p_ack, 4'b0001 << exp_idx); end
      read_beats(4);
      if (k == 7) ifc.p_req = 4'b0000;
      total++; if (ifc.busy !== 1'b0 || ifc.sdc_req !== 1'b0) begin bad++; $display("FAIL rr_idle_gap k=%0d got=%0h/%0h exp=0/0", k, ifc.busy, ifc.sdc_req); end
    end
    cyc();
  endtask

  task automatic test_ack_with_beat();
    ifc.p_req_len  = 8'h00;
    ifc.p_req_wr_n = 4'b1111;
    ifc.p_req      = 4'b0001;
    cyc();
    total++; if (ifc.grant !== 4'b0001) begin bad++; $display("FAIL ackbeat_grant got=%0h exp=1", ifc.grant); end
    ifc.sdc_req_ack  = 1'b1;
    ifc.sdc_rd_valid = 1'b1;
    #1;
    total++; if (ifc.p_rd_valid !== 4'b0001) begin bad++; $display("FAIL ackbeat_route got=%0h exp=1", ifc.p_rd_valid); end
    ifc.p_req = 4'b0000;
    cyc();
    ifc.sdc_req_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL ackbeat_busy i=%0d got=%0h exp=1", i, ifc.busy); end
      cyc();
    end
    ifc.sdc_rd_valid = 1'b0;
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL ackbeat_end got=%0h exp=0", ifc.busy); end
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    ifc.p_req_len[5:4] = 2'd2;
    ifc.p_req_wr_n[2]  = 1'b0;
    ifc.p_req = 4'b0100;
    cyc();
    total++; if (ifc.grant !== 4'b0100) begin bad++; $display("FAIL mid_grant got=%0h exp=4", ifc.grant); end
    ack_now();
    ifc.p_req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ifc.sdc_wr_next = 1'b1;
      cyc();
    end
    ifc.sdc_wr_next = 1'b1;
    #1;
    s_resetn = 1'b0;
    #1;
    total++; if (ifc.sdc_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%0h exp=0", ifc.sdc_req); end
    total++; if (ifc.grant !== 4'h0) begin bad++; $display("FAIL mid_rst_grant got=%0h exp=0", ifc.grant); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0h exp=0", ifc.busy); end
    total++; if (ifc.p_wr_next !== 4'h0) begin bad++; $display("FAIL mid_rst_wr_next got=%0h exp=0", ifc.p_wr_next); end
    ifc.sdc_wr_next = 1'b0;
    cyc();
    s_resetn = 1'b1;
    cyc();
    ifc.p_req_wr_n = 4'b1111;
    ifc.p_req_len  = 8'h00;
    ifc.p_req_adr[0 +: ADDR_W] = 23'h7000;
    ifc.p_req_adr[3*ADDR_W +: ADDR_W] = 23'h7003;
    ifc.p_req = 4'b1001;
    cyc();
    total++; if (ifc.grant !== 4'b0001) begin bad++; $display("FAIL post_rst_grant got=%0h exp=1", ifc.grant); end
    total++; if (ifc.sdc_req_adr !== 23'h7000) begin bad++; $display("FAIL post_rst_adr got=%0h exp=7000", ifc.sdc_req_adr); end
    ack_now();
    ifc.p_req = 4'b0000;
    read_beats(4);
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL post_rst_end got=%0h exp=0", ifc.busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_init_gate();
    test_write_burst();
    test_read_burst();
    test_round_robin();
    test_ack_with_beat();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdc_port_arbiter.md
Name: sdc_port_arbiter

Overview:
- Four-requester round-robin arbiter in front of the SDRAM controller user port (sdc_req / sdc_req_ack / sdc_wr_next / sdc_rd_valid handshake).
- Latches one request per grant and drives it to the controller.
- Routes the write-data, write-strobe and read-valid beats between the controller and the granted requester until the burst completes.
- Sits between the system masters and the SDRAM controller, in the same mclk domain.

Parameters:
ADDR_W, 23, user address width (bank+row+col)
DATA_W, 32, user data width
BE_W, 4, write byte-enable width (active-low strobes)

Ports:
mclk  in  1  system clock, all logic on posedge
s_resetn  in  1  asynchronous active-low reset
sdc_init_done  in  1  controller initialisation complete; no grant while low
p_req  in  4  per-port request, held high until that port's p_ack
p_req_adr  in  4*ADDR_W  per-port address, port n at [n*ADDR_W +: ADDR_W]
p_req_len  in  8  per-port length code, port n at [2n+:2]
p_req_wr_n  in  4  per-port direction, 0 = write, 1 = read
p_wr_data  in  4*DATA_W  per-port write data
p_wr_en_n  in  4*BE_W  per-port write byte mask
p_ack  out  4  one-cycle pulse to the granted port when the controller accepts
p_wr_next  out  4  controller sdc_wr_next routed to the granted port
p_rd_valid  out  4  controller sdc_rd_valid routed to the granted port
p_rd_data  out  DATA_W  sdc_rd_data broadcast to all ports
grant  out  4  one-hot current owner, 0 when idle
busy  out  1  high in any state other than IDLE
sdc_req  out  1  request to controller
sdc_req_adr  out  ADDR_W  latched address
sdc_req_len  out  2  latched length code
sdc_req_wr_n  out  1  latched direction
sdc_wr_data  out  DATA_W  granted port's p_wr_data (combinational mux)
sdc_wr_en_n  out  BE_W  granted port's p_wr_en_n (combinational mux); all-ones when idle
sdc_req_ack  in  1  controller accepted request
sdc_wr_next  in  1  controller consumes one write word this cycle
sdc_rd_valid  in  1  sdc_rd_data valid this cycle
sdc_rd_data  in  DATA_W  controller read data

Behaviour:

Reset values:
- sdc_req = 0; sdc_req_adr, sdc_req_len, sdc_req_wr_n, grant, p_ack, busy = 0.
- last-grant pointer = 3, so port 0 has first priority.
- Beat counter = 0.
- State = IDLE.

Burst length:
- Words = 4 << len: len 0..3 gives 4, 8, 16, 32.
- Counter is 6 bits; the last beat is beat_cnt == words-1.

States:
- IDLE:
  - If sdc_init_done and |p_req, select the first requesting port scanning from pointer+1 mod 4.
  - Latch that port's adr, len and wr_n into the sdc_req_* registers, set grant, set sdc_req = 1, go to REQ. All of this is registered, so sdc_req rises the cycle after p_req is seen.
  - Otherwise stay in IDLE.
- REQ:
  - Hold sdc_req high and all latched fields stable until sdc_req_ack = 1.
  - On the ack cycle: sdc_req = 0 next cycle, p_ack[grant] pulses high for exactly one cycle next cycle, pointer is set to the granted index, go to WDATA if write, RDATA if read.
- WDATA:
  - p_wr_next = grant & {4{sdc_wr_next}}, combinational.
  - Each sdc_wr_next increments beat_cnt. On the last beat, go to IDLE with beat_cnt = 0 and grant = 0.
- RDATA:
  - Same as WDATA, using sdc_rd_valid and p_rd_valid.

Beat counting:
- Beats are counted in REQ as well as in WDATA/RDATA, so a wr_next or rd_valid coinciding with the ack cycle is routed and counted.
- Outside REQ/WDATA/RDATA, p_wr_next and p_rd_valid are 0 and controller beats are ignored.

Arbitration and requester rules:
- Arbitration takes one idle cycle minimum after completion; back-to-back grants are separated by at least one IDLE cycle.
- A requester dropping p_req before being selected loses nothing.
- Once a request is latched, the transaction completes regardless of p_req. The requester must supply p_wr_data and p_wr_en_n whenever p_wr_next is high.
- sdc_init_done falling mid-transaction does not abort; it only blocks the next grant.

Reset and fairness:
- Asynchronous reset at any point returns to IDLE immediately: sdc_req = 0, grant = 0, in-flight beats are discarded.
- Fairness: a continuously requesting port waits at most 3 other transactions.

Test Plan:
- Reset, then sdc_init_done = 0 with p_req = 4'b0001 -> no sdc_req. Raise init_done -> sdc_req = 1 one cycle later with sdc_req_adr = port0 adr, grant = 4'b0001.
- Port 2 write, len 1, ack after 3 cycles, then 8 sdc_wr_next pulses -> p_ack[2] single pulse, p_wr_next[2] exactly 8 pulses, sdc_wr_data tracks port 2 data, return to IDLE after the 8th pulse.
- Port 1 read, len 3 -> 32 sdc_rd_valid pulses appear only on p_rd_valid[1]. Extra rd_valid after the 32nd is not routed.
- All four ports requesting continuously with len 0 -> grant order 0,1,2,3,0,… and each p_ack pulses once per round.
- Read with sdc_rd_valid asserted in the same cycle as sdc_req_ack -> that beat is counted, and 4 total beats end the len-0 burst.
- s_resetn low during WDATA beat 5 of 16 -> sdc_req = 0, grant = 0, busy = 0 immediately. After release, port 0 has priority.
